// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct, ALU and next-PC codes (MIPS_CTRL_BNE_EN adds bne)
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      RTYPEEX = 4'd7,
      RTYPEWB = 4'd8,
      BEQEX   = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JEX     = 4'd12,
      HALT    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Next-PC mux selects, also decoded by the datapath mux
   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_IMMX4     = 2'b10;
   localparam logic [1:0] PCSRC_HOLD      = 2'b11;

   localparam logic [1:0] SRCB_REGB     = 2'b00;
   localparam logic [1:0] SRCB_FOUR     = 2'b01;
   localparam logic [1:0] SRCB_IMM      = 2'b10;
   localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

   function automatic logic opcode_legal(input logic [5:0] op);
      logic ok;
      ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MIPS_CTRL_BNE_EN
      ok = ok || (op == OP_BNE);
`endif
      return ok;
   endfunction

endpackage

// File: rtl/mips_ctrl_fsm_alu_dec.sv
// rtl/mips_ctrl_fsm_alu_dec.sv - R-type Funct to ALUControl decode
module mips_alu_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_SLT:  alu_control = ALU_SLT;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multicycle MIPS control FSM (MIPS_CTRL_BNE_EN enables bne)
module mips_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCEn,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IorD,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [3:0] State,
   output logic       Illegal
);

   state_t     state, state_next;
   logic [2:0] rtype_alu;

   mips_alu_dec u_alu_dec (
      .funct       (Funct),
      .alu_control (rtype_alu)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = FETCH;
         FETCH:   state_next = DECODE;
         DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = RTYPEEX;
               OP_BEQ:       state_next = BEQEX;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:       state_next = BEQEX;
`endif
               OP_ADDI:      state_next = ADDIEX;
               OP_J:         state_next = JEX;
               default:      state_next = HALT_ON_ILLEGAL ? HALT : FETCH;
            endcase
         end
         MEMADR:  state_next = (Opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_next = MEMWB;
         MEMWB:   state_next = FETCH;
         MEMWR:   state_next = FETCH;
         RTYPEEX: state_next = RTYPEWB;
         RTYPEWB: state_next = FETCH;
         ADDIEX:  state_next = ADDIWB;
         ADDIWB:  state_next = FETCH;
         BEQEX:   state_next = FETCH;
         JEX:     state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      PCEn       = 1'b0;
      PCSrc      = PCSRC_HOLD;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IorD       = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REGB;
      ALUControl = ALU_AND;
      Illegal    = 1'b0;
      case (state)
         IDLE:    ALUControl = ALU_ADD;
         FETCH: begin
            ALUSrcB    = SRCB_FOUR;
            ALUControl = ALU_ADD;
            IRWrite    = 1'b1;
            PCSrc      = PCSRC_ALURESULT;
            PCEn       = 1'b1;
         end
         DECODE: begin
            ALUSrcB    = SRCB_IMM_SHL2;
            ALUControl = ALU_ADD;
            Illegal    = !opcode_legal(Opcode);
         end
         MEMADR, ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = ALU_ADD;
         end
         MEMRD:   IorD = 1'b1;
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         RTYPEEX: begin
            ALUSrcA    = 1'b1;
            ALUControl = rtype_alu;
         end
         RTYPEWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         ADDIWB:  RegWrite = 1'b1;
         BEQEX: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = PCSRC_ALUOUT;
`ifdef MIPS_CTRL_BNE_EN
            PCEn       = (Opcode == OP_BNE) ? !Zero : Zero;
`else
            PCEn       = Zero;
`endif
         end
         JEX: begin
            PCSrc = PCSRC_IMMX4;
            PCEn  = 1'b1;
         end
         default: ;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - self-checking bench for mips_ctrl_fsm (honours MIPS_CTRL_BNE_EN)
module tb_mips_ctrl_fsm;
   import mips_ctrl_pkg::*;

   logic       clk, rst_n, Zero;
   logic [5:0] Opcode, Funct;
   logic       PCEn, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA, Illegal;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALUControl;
   logic [3:0] State;
   logic       h_PCEn, h_IRWrite, h_MemWrite, h_RegWrite, h_IorD, h_RegDst, h_MemtoReg, h_ALUSrcA, h_Illegal;
   logic [1:0] h_PCSrc, h_ALUSrcB;
   logic [2:0] h_ALUControl;
   logic [3:0] h_State;

   mips_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .PCEn(PCEn), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .State(State), .Illegal(Illegal));

   mips_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .PCEn(h_PCEn), .PCSrc(h_PCSrc), .IRWrite(h_IRWrite), .MemWrite(h_MemWrite),
      .RegWrite(h_RegWrite), .IorD(h_IorD), .RegDst(h_RegDst), .MemtoReg(h_MemtoReg),
      .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUControl(h_ALUControl),
      .State(h_State), .Illegal(h_Illegal));

   typedef struct packed {
      logic       pcen;
      logic [1:0] pcsrc;
      logic       irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluctl;
      logic       illegal;
   } exp_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   state_t exp_q[$];
   state_t cmp_s;
   exp_t   cmp_e;
   logic   halt_watch = 1'b0;
   int     halt_cycles = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bench_legal(input logic [5:0] op);
`ifdef MIPS_CTRL_BNE_EN
      if (op == 6'b000101) return 1'b1;
`endif
      return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   function automatic logic [2:0] bench_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Per-state output rules; anything not named is 0 and PCSrc is 11
   function automatic exp_t exp_outputs(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
      exp_t e;
      e = '0;
      e.pcsrc = 2'b11;
      case (s)
         IDLE:    e.aluctl = 3'b010;
         FETCH:   begin e.irwrite = 1; e.alusrcb = 2'b01; e.aluctl = 3'b010; e.pcsrc = 2'b00; e.pcen = 1; end
         DECODE:  begin e.alusrcb = 2'b11; e.aluctl = 3'b010; e.illegal = !bench_legal(op); end
         MEMADR, ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
         MEMRD:   e.iord = 1;
         MEMWR:   begin e.iord = 1; e.memwrite = 1; end
         MEMWB:   begin e.regwrite = 1; e.memtoreg = 1; end
         RTYPEEX: begin e.alusrca = 1; e.aluctl = bench_alu(fn); end
         RTYPEWB: begin e.regwrite = 1; e.regdst = 1; end
         ADDIWB:  e.regwrite = 1;
         BEQEX: begin
            e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
            e.pcen = (op == 6'b000101) ? !z : z;
         end
         JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic push_seq(input logic [5:0] op);
      exp_q.push_back(FETCH);
      exp_q.push_back(DECODE);
      case (op)
         6'b100011: begin exp_q.push_back(MEMADR); exp_q.push_back(MEMRD); exp_q.push_back(MEMWB); end
         6'b101011: begin exp_q.push_back(MEMADR); exp_q.push_back(MEMWR); end
         6'b000000: begin exp_q.push_back(RTYPEEX); exp_q.push_back(RTYPEWB); end
         6'b001000: begin exp_q.push_back(ADDIEX); exp_q.push_back(ADDIWB); end
         6'b000100: exp_q.push_back(BEQEX);
         6'b000010: exp_q.push_back(JEX);
         default:   if (bench_legal(op)) exp_q.push_back(BEQEX);
      endcase
   endtask

   // Hand-computed literals at chosen cycles after FETCH
   task automatic probe(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
      if (op == 6'b000000 && fn == 6'b100010 && n == 2) check("rsub_aluctl", ALUControl, 3'b110);
      if (op == 6'b000000 && fn == 6'b100010 && n == 3) check("rsub_wb", {RegDst, RegWrite}, 2'b11);
      if (op == 6'b000100 && n == 2) check("beq_pc", {PCEn, PCSrc}, {z, 2'b01});
      if (op == 6'b000010 && n == 1) check("j_decode_pcsrc", PCSrc, 2'b11);
      if (op == 6'b000010 && n == 2) check("j_pc", {PCEn, PCSrc}, 3'b110);
      if (op == 6'b100011 && n == 4) check("lw_wb", {RegWrite, MemtoReg}, 2'b11);
      if (op == 6'b111111 && n == 1) check("illegal_pulse", Illegal, 1);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lat);
      int n;
      Opcode = op; Funct = fn; Zero = z;
      push_seq(op);
      n = 0;
      do begin
         @(posedge clk); #2; n++;
         probe(op, fn, z, n);
      end while (State != 4'(FETCH) && n < 8);
      check($sformatf("latency_op%b", op), n, lat);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         cmp_s = exp_q.pop_front();
         cmp_e = exp_outputs(cmp_s, Opcode, Funct, Zero);
         check("State", State, cmp_s);
         check("PCEn", PCEn, cmp_e.pcen);
         check("PCSrc", PCSrc, cmp_e.pcsrc);
         check("IRWrite", IRWrite, cmp_e.irwrite);
         check("MemWrite", MemWrite, cmp_e.memwrite);
         check("RegWrite", RegWrite, cmp_e.regwrite);
         check("IorD", IorD, cmp_e.iord);
         check("RegDst", RegDst, cmp_e.regdst);
         check("MemtoReg", MemtoReg, cmp_e.memtoreg);
         check("ALUSrcA", ALUSrcA, cmp_e.alusrca);
         check("ALUSrcB", ALUSrcB, cmp_e.alusrcb);
         check("ALUControl", ALUControl, cmp_e.aluctl);
         check("Illegal", Illegal, cmp_e.illegal);
      end
      if (halt_watch) begin
         halt_cycles++;
         check("halt_state", h_State, HALT);
         check("halt_strobes", {h_PCEn, h_IRWrite, h_MemWrite, h_RegWrite, h_PCSrc}, 6'b000011);
      end
   end

   initial begin
      rst_n = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
      @(posedge clk); #2;
      check("reset_state", State, 0);
      check("reset_idle_alu", {ALUControl, PCSrc, Illegal}, 6'b010110);
      @(posedge clk); #2;
      exp_q.push_back(IDLE);
      rst_n = 1'b1;
      @(posedge clk); #2;
      check("first_fetch", {State, IRWrite, PCEn}, {4'(FETCH), 2'b11});

      run_instr(6'b100011, 6'b000000, 1'b0, 5);
      run_instr(6'b101011, 6'b000000, 1'b0, 4);
      run_instr(6'b000000, 6'b100000, 1'b0, 4);
      run_instr(6'b000000, 6'b100010, 1'b0, 4);
      run_instr(6'b000000, 6'b100100, 1'b0, 4);
      run_instr(6'b000000, 6'b100101, 1'b0, 4);
      run_instr(6'b000000, 6'b101010, 1'b0, 4);
      run_instr(6'b000000, 6'b111111, 1'b0, 4);
      run_instr(6'b001000, 6'b000000, 1'b0, 4);
      run_instr(6'b000100, 6'b000000, 1'b1, 3);
      run_instr(6'b000100, 6'b000000, 1'b0, 3);
      run_instr(6'b000010, 6'b000000, 1'b0, 3);
`ifdef MIPS_CTRL_BNE_EN
      run_instr(6'b000101, 6'b000000, 1'b0, 3);
      run_instr(6'b000101, 6'b000000, 1'b1, 3);
`else
      run_instr(6'b000101, 6'b000000, 1'b0, 2);
`endif
      run_instr(6'b111111, 6'b000000, 1'b0, 2);
      halt_watch = 1'b1;
      run_instr(6'b100011, 6'b000000, 1'b0, 5);
      run_instr(6'b101011, 6'b000000, 1'b0, 4);
      run_instr(6'b000000, 6'b100101, 1'b0, 4);
      halt_watch = 1'b0;
      check("halt_cycles_ge10", int'(halt_cycles >= 10), 1);

      // Pull reset in the middle of a store
      Opcode = 6'b101011; Funct = '0; Zero = 1'b0;
      push_seq(6'b101011);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("memwr_before_reset", MemWrite, 1);
      #1 rst_n = 1'b0;
      #1;
      check("memwrite_async_drop", MemWrite, 0);
      check("async_idle", State, 0);
      check("halt_dut_reset", h_State, 0);
      exp_q.delete();
      @(posedge clk); #2;
      exp_q.push_back(IDLE);
      rst_n = 1'b1;
      @(posedge clk); #2;
      check("restart_fetch", State, 1);
      run_instr(6'b100011, 6'b000000, 1'b0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
